// File: rtl/mux_tree_tapbuf_mem_dbuf_pkg.sv
// Shared types and helpers for the double-buffered configuration memory.
package ccff_mem_pkg;

  // Load progress, decoded from the shift counter.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } ccff_state_e;

  // Width of a counter that must represent 0..width inclusive.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mux_tree_tapbuf_mem_dbuf_shadow_chain.sv
// Shadow shift chain: WIDTH-bit enabled shift register, serial in at bit 0.
module ccff_shadow_chain #(
  parameter int              WIDTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_din,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (WIDTH == 1) begin : g_single
      // Single-bit chain: the flop just captures the serial input.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)     o_q <= RESET_VAL;
        else if (i_en) o_q <= i_din;
      end
    end else begin : g_multi
      // Shift toward the MSB; the MSB flop is the serial output.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)     o_q <= RESET_VAL;
        else if (i_en) o_q <= {o_q[WIDTH-2:0], i_din};
      end
    end
  endgenerate

endmodule

// File: rtl/mux_tree_tapbuf_mem_dbuf.sv
// Double-buffered mux configuration memory: serial shadow chain plus an
// active register that only changes on an accepted commit or on reset.
module mux_tree_tapbuf_mem_dbuf
  import ccff_mem_pkg::*;
#(
  parameter int               WIDTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = cnt_w(WIDTH)
) (
  input  logic          prog_clk,
  input  logic          prog_reset,
  input  logic          ccff_head,
  input  logic          ccff_en,
  input  logic          ccff_commit,
  output logic          ccff_tail,
  output logic [0:WIDTH-1] mem_out,
  output logic [0:WIDTH-1] mem_outb,
  output logic [CW-1:0] shift_cnt,
  output logic          loaded,
  output logic          overflow,
  output logic          commit_rej
);

  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

  logic [WIDTH-1:0] w_shadow;
  logic [WIDTH-1:0] r_active;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic             r_rej;
  ccff_state_e      w_state;
  logic             w_accept;

  ccff_shadow_chain #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_chain (
    .i_clk(prog_clk),
    .i_rst(prog_reset),
    .i_en (ccff_en),
    .i_din(ccff_head),
    .o_q  (w_shadow)
  );

  // Load state is a pure decode of the shift counter.
  always_comb begin
    w_state = ST_FILLING;
    if (r_cnt == '0)          w_state = ST_EMPTY;
    else if (r_cnt == FULL_CNT) w_state = ST_FULL;
  end

  // A commit is only taken on a full, quiet chain; a simultaneous shift wins.
  assign w_accept = ccff_commit && !ccff_en && (w_state == ST_FULL);

  // Counter, sticky overflow, reject pulse and active register.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      r_active <= RESET_VAL;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_rej    <= 1'b0;
    end else begin
      r_rej <= ccff_commit && !w_accept;
      if (w_accept) begin
        r_active <= w_shadow;
        r_cnt    <= '0;
        r_ovf    <= 1'b0;
      end else if (ccff_en) begin
        if (w_state == ST_FULL) r_ovf <= 1'b1;
        else                    r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign ccff_tail  = w_shadow[WIDTH-1];
  assign mem_out    = r_active;
  assign mem_outb   = ~r_active;
  assign shift_cnt  = r_cnt;
  assign loaded     = (w_state == ST_FULL);
  assign overflow   = r_ovf;
  assign commit_rej = r_rej;

endmodule

// File: tb/tb_mux_tree_tapbuf_mem_dbuf.sv
// Directed bench: WIDTH=3 functional cases, async reset with non-zero
// reset value, and two-deep chains at WIDTH=1 and WIDTH=64.
module tb_mux_tree_tapbuf_mem_dbuf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic rst, rst_b;

  // instance A: WIDTH=3, zero reset value
  logic a_head, a_en, a_cm, a_tail, a_ld, a_ov, a_rej;
  logic [0:2] a_mo, a_mob;
  logic [1:0] a_cnt;

  // instance B: WIDTH=3, reset value 110
  logic b_head, b_en, b_cm, b_tail, b_ld, b_ov, b_rej;
  logic [0:2] b_mo, b_mob;
  logic [1:0] b_cnt;

  // WIDTH=1 chain
  logic c1_head, c1_en, c1_cm, c1_mid, c1_tail;
  logic c1a_ld, c1a_ov, c1a_rej, c1b_ld, c1b_ov, c1b_rej;
  logic [0:0] c1a_mo, c1a_mob, c1b_mo, c1b_mob, c1a_cnt, c1b_cnt;

  // WIDTH=64 chain
  logic c6_head, c6_en, c6_cm, c6_mid, c6_tail;
  logic c6a_ld, c6a_ov, c6a_rej, c6b_ld, c6b_ov, c6b_rej;
  logic [0:63] c6a_mo, c6a_mob, c6b_mo, c6b_mob;
  logic [6:0] c6a_cnt, c6b_cnt;

  mux_tree_tapbuf_mem_dbuf #(.WIDTH(3), .RESET_VAL(3'b000)) dut_a (
    .prog_clk(clk), .prog_reset(rst), .ccff_head(a_head), .ccff_en(a_en),
    .ccff_commit(a_cm), .ccff_tail(a_tail), .mem_out(a_mo), .mem_outb(a_mob),
    .shift_cnt(a_cnt), .loaded(a_ld), .overflow(a_ov), .commit_rej(a_rej));

  mux_tree_tapbuf_mem_dbuf #(.WIDTH(3), .RESET_VAL(3'b110)) dut_b (
    .prog_clk(clk), .prog_reset(rst_b), .ccff_head(b_head), .ccff_en(b_en),
    .ccff_commit(b_cm), .ccff_tail(b_tail), .mem_out(b_mo), .mem_outb(b_mob),
    .shift_cnt(b_cnt), .loaded(b_ld), .overflow(b_ov), .commit_rej(b_rej));

  mux_tree_tapbuf_mem_dbuf #(.WIDTH(1)) dut_c1a (
    .prog_clk(clk), .prog_reset(rst), .ccff_head(c1_head), .ccff_en(c1_en),
    .ccff_commit(c1_cm), .ccff_tail(c1_mid), .mem_out(c1a_mo), .mem_outb(c1a_mob),
    .shift_cnt(c1a_cnt), .loaded(c1a_ld), .overflow(c1a_ov), .commit_rej(c1a_rej));

  mux_tree_tapbuf_mem_dbuf #(.WIDTH(1)) dut_c1b (
    .prog_clk(clk), .prog_reset(rst), .ccff_head(c1_mid), .ccff_en(c1_en),
    .ccff_commit(c1_cm), .ccff_tail(c1_tail), .mem_out(c1b_mo), .mem_outb(c1b_mob),
    .shift_cnt(c1b_cnt), .loaded(c1b_ld), .overflow(c1b_ov), .commit_rej(c1b_rej));

  mux_tree_tapbuf_mem_dbuf #(.WIDTH(64)) dut_c6a (
    .prog_clk(clk), .prog_reset(rst), .ccff_head(c6_head), .ccff_en(c6_en),
    .ccff_commit(c6_cm), .ccff_tail(c6_mid), .mem_out(c6a_mo), .mem_outb(c6a_mob),
    .shift_cnt(c6a_cnt), .loaded(c6a_ld), .overflow(c6a_ov), .commit_rej(c6a_rej));

  mux_tree_tapbuf_mem_dbuf #(.WIDTH(64)) dut_c6b (
    .prog_clk(clk), .prog_reset(rst), .ccff_head(c6_mid), .ccff_en(c6_en),
    .ccff_commit(c6_cm), .ccff_tail(c6_tail), .mem_out(c6b_mo), .mem_outb(c6b_mob),
    .shift_cnt(c6b_cnt), .loaded(c6b_ld), .overflow(c6b_ov), .commit_rej(c6b_rej));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step_a(input logic en, input logic head, input logic cm);
    a_en = en; a_head = head; a_cm = cm;
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic en, input logic head, input logic cm);
    b_en = en; b_head = head; b_cm = cm;
    @(posedge clk); #1;
  endtask

  task automatic step_c1(input logic en, input logic head, input logic cm);
    c1_en = en; c1_head = head; c1_cm = cm;
    @(posedge clk); #1;
  endtask

  task automatic step_c6(input logic en, input logic head, input logic cm);
    c6_en = en; c6_head = head; c6_cm = cm;
    @(posedge clk); #1;
  endtask

  logic [127:0] pat;
  logic [63:0]  e6a, e6b;

  initial begin
    {a_head, a_en, a_cm, b_head, b_en, b_cm} = '0;
    {c1_head, c1_en, c1_cm, c6_head, c6_en, c6_cm} = '0;
    rst = 1'b1; rst_b = 1'b1;
    #2;
    chk("rst_a_mo",   64'(a_mo),  64'h0);
    chk("rst_a_mob",  64'(a_mob), 64'h7);
    chk("rst_a_cnt",  64'(a_cnt), 64'h0);
    chk("rst_a_flag", {61'h0, a_ld, a_ov, a_rej}, 64'h0);
    chk("rst_a_tail", 64'(a_tail), 64'h0);
    chk("rst_b_mo",   64'(b_mo),  64'h6);
    chk("rst_b_mob",  64'(b_mob), 64'h1);
    chk("rst_b_tail", 64'(b_tail), 64'h1);
    @(posedge clk); #1;
    chk("rst_hold_a_cnt", 64'(a_cnt), 64'h0);
    @(negedge clk);
    rst = 1'b0; rst_b = 1'b0;

    // basic load 1,0,1 then commit
    step_a(1, 1, 0);
    chk("a_cnt1", 64'(a_cnt), 64'h1);
    step_a(1, 0, 0);
    step_a(1, 1, 0);
    chk("a_full_cnt",  64'(a_cnt), 64'h3);
    chk("a_full_ld",   64'(a_ld),  64'h1);
    chk("a_full_mo",   64'(a_mo),  64'h0);
    chk("a_full_tail", 64'(a_tail), 64'h1);
    step_a(0, 0, 1);
    chk("a_cm_mo",  64'(a_mo),  64'h5);
    chk("a_cm_mob", 64'(a_mob), 64'h2);
    chk("a_cm_cnt", 64'(a_cnt), 64'h0);
    chk("a_cm_rej", 64'(a_rej), 64'h0);

    // commit refused on partial load
    step_a(1, 0, 0);
    step_a(1, 0, 0);
    step_a(0, 0, 1);
    chk("a_rej_pulse", 64'(a_rej), 64'h1);
    chk("a_rej_mo",    64'(a_mo),  64'h5);
    chk("a_rej_cnt",   64'(a_cnt), 64'h2);
    step_a(0, 0, 0);
    chk("a_rej_end",   64'(a_rej), 64'h0);
    step_a(1, 0, 0);
    step_a(0, 0, 1);
    chk("a_cm0_mo", 64'(a_mo), 64'h0);

    // overflow: four shifts 1,0,0,1
    step_a(1, 1, 0);
    step_a(1, 0, 0);
    step_a(1, 0, 0);
    chk("a_ov_tail_first", 64'(a_tail), 64'h1);
    chk("a_ov_pre",        64'(a_ov),   64'h0);
    step_a(1, 1, 0);
    chk("a_ov_set",  64'(a_ov),   64'h1);
    chk("a_ov_cnt",  64'(a_cnt),  64'h3);
    chk("a_ov_tail", 64'(a_tail), 64'h0);
    chk("a_ov_mo",   64'(a_mo),   64'h0);
    step_a(0, 0, 1);
    chk("a_ov_clr",  64'(a_ov),  64'h0);
    chk("a_ov_cmmo", 64'(a_mo),  64'h1);

    // commit together with shift while full
    step_a(1, 1, 0);
    step_a(1, 1, 0);
    step_a(1, 0, 0);
    step_a(1, 1, 1);
    chk("a_both_rej",  64'(a_rej),  64'h1);
    chk("a_both_mo",   64'(a_mo),   64'h1);
    chk("a_both_ov",   64'(a_ov),   64'h1);
    chk("a_both_tail", 64'(a_tail), 64'h1);
    step_a(0, 0, 0);
    chk("a_both_rej0", 64'(a_rej), 64'h0);
    step_a(0, 0, 1);
    chk("a_both_cmmo", 64'(a_mo), 64'h5);
    chk("a_both_cmov", 64'(a_ov), 64'h0);
    step_a(0, 0, 0);

    // async reset mid-load, reset value 110
    step_b(1, 0, 0);
    step_b(1, 0, 0);
    step_b(1, 0, 0);
    step_b(0, 0, 1);
    chk("b_cm_mo", 64'(b_mo), 64'h0);
    step_b(1, 1, 0);
    chk("b_part_cnt", 64'(b_cnt), 64'h1);
    b_en = 1'b0;
    #2 rst_b = 1'b1;
    #1;
    chk("b_arst_mo",   64'(b_mo),   64'h6);
    chk("b_arst_mob",  64'(b_mob),  64'h1);
    chk("b_arst_cnt",  64'(b_cnt),  64'h0);
    chk("b_arst_ov",   64'(b_ov),   64'h0);
    chk("b_arst_tail", 64'(b_tail), 64'h1);
    @(negedge clk);
    rst_b = 1'b0;
    step_b(1, 0, 0);
    chk("b_restart_cnt",  64'(b_cnt),  64'h1);
    chk("b_restart_tail", 64'(b_tail), 64'h1);
    step_b(1, 1, 0);
    step_b(1, 1, 0);
    step_b(0, 0, 1);
    chk("b_reload_mo", 64'(b_mo), 64'h3);
    step_b(0, 0, 0);

    // WIDTH=1 two-deep chain
    step_c1(1, 1, 0);
    chk("c1_s1_tail", 64'(c1_tail), 64'h0);
    chk("c1_s1_cnt",  64'(c1a_cnt), 64'h1);
    chk("c1_s1_ld",   64'(c1b_ld),  64'h1);
    step_c1(1, 0, 0);
    chk("c1_s2_tail", 64'(c1_tail), 64'h1);
    chk("c1_s2_ov",   64'({c1a_ov, c1b_ov}), 64'h3);
    step_c1(0, 0, 1);
    chk("c1_cm_mo",  64'({c1a_mo, c1b_mo}), 64'h1);
    chk("c1_cm_mob", 64'({c1a_mob, c1b_mob}), 64'h2);
    chk("c1_cm_ov",  64'({c1a_ov, c1b_ov}), 64'h0);
    step_c1(0, 0, 0);

    // WIDTH=64 two-deep chain: bit n enters on shift n
    pat = {64'hDEAD_BEEF_0123_4567, 64'h8C3A_5F10_9E2B_7D41};
    for (int n = 0; n < 128; n++) begin
      step_c6(1, pat[n], 0);
      if (n == 126) chk("c6_tail_early", 64'(c6_tail), 64'h0);
    end
    chk("c6_tail_emerge", 64'(c6_tail), 64'(pat[0]));
    chk("c6_cnt_sat",     64'({c6a_cnt, c6b_cnt}), 64'h2040);
    chk("c6_ov",          64'({c6a_ov, c6b_ov}), 64'h3);
    chk("c6_pre_mo",      64'(c6b_mo), 64'h0);
    step_c6(0, 0, 1);
    for (int i = 0; i < 64; i++) begin
      e6a[i] = pat[127 - i];
      e6b[i] = pat[63 - i];
    end
    chk("c6a_mo",  64'(c6a_mo),  e6a);
    chk("c6b_mo",  64'(c6b_mo),  e6b);
    chk("c6b_mob", 64'(c6b_mob), ~e6b);
    chk("c6_cm_cnt", 64'({c6a_cnt, c6b_cnt}), 64'h0);
    chk("c6_cm_ov",  64'({c6a_ov, c6b_ov}), 64'h0);
    step_c6(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_tree_tapbuf_mem_dbuf.md
MUX_TREE_TAPBUF_MEM_DBUF -- requirements
Module: mux_tree_tapbuf_mem_dbuf

Interface
REQ-001 SHALL have parameter WIDTH, default 3: number of configuration bits; legal range 1..64.
REQ-002 SHALL have parameter RESET_VAL, default all-zero WIDTH-bit vector: value loaded into shadow and active registers at reset.
REQ-003 SHALL have port prog_clk, input, 1 bit: programming clock; all state changes on its rising edge.
REQ-004 SHALL have port prog_reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port ccff_head, input, 1 bit: serial configuration data in.
REQ-006 SHALL have port ccff_en, input, 1 bit: shift enable for the shadow chain.
REQ-007 SHALL have port ccff_commit, input, 1 bit: request to copy the shadow chain into the active register.
REQ-008 SHALL have port ccff_tail, output, 1 bit: serial data out, equal to shadow bit WIDTH-1.
REQ-009 SHALL have port mem_out, output, WIDTH bits [0:WIDTH-1]: active configuration driving the mux.
REQ-010 SHALL have port mem_outb, output, WIDTH bits [0:WIDTH-1]: bitwise complement of mem_out.
REQ-011 SHALL have port shift_cnt, output, CW=$clog2(WIDTH+1) bits: number of shifts since last commit or reset, saturating.
REQ-012 SHALL have port loaded, output, 1 bit: high when shift_cnt == WIDTH.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag for a shift attempted while loaded.
REQ-014 SHALL have port commit_rej, output, 1 bit: one-cycle pulse when a commit is refused.

Function
REQ-015 SHALL hold a WIDTH-bit shadow shift register and a separate WIDTH-bit active register; mem_out SHALL come only from the active register.
REQ-016 SHALL, on a cycle with ccff_en=1, update shadow[0]<=ccff_head and shadow[i]<=shadow[i-1] for i=1..WIDTH-1; shadow SHALL hold when ccff_en=0.
REQ-017 SHALL drive ccff_tail combinationally from the shadow[WIDTH-1] flop, so a bit entering ccff_head appears at ccff_tail after exactly WIDTH enabled shifts.
REQ-018 SHALL implement three states derived from shift_cnt: EMPTY (0), FILLING (1..WIDTH-1), FULL (WIDTH).
REQ-019 SHALL increment shift_cnt by 1 on each enabled shift below WIDTH, and hold it at WIDTH when FULL.
REQ-020 SHALL set overflow on a cycle with ccff_en=1 in FULL; the shift still occurs, and overflow SHALL remain set until the next accepted commit or reset.
REQ-021 SHALL accept a commit when ccff_commit=1, ccff_en=0 and state is FULL: active<=shadow, shift_cnt<=0 and overflow<=0 on the same edge; mem_out SHALL change on that edge (latency 1).
REQ-022 SHALL refuse a commit when ccff_commit=1 and either state is not FULL or ccff_en=1; it SHALL pulse commit_rej high for exactly one cycle and leave active unchanged.
REQ-023 SHALL process the shift normally when ccff_commit=1 and ccff_en=1 in the same cycle; the commit is refused.
REQ-024 SHALL keep mem_out stable during shifting; mem_out SHALL change only on an accepted commit or on reset.
REQ-025 SHALL make mem_outb == ~mem_out at all times, including during reset.

Reset
REQ-026 SHALL, while prog_reset=1 and independent of prog_clk, force: shadow=RESET_VAL, active=RESET_VAL, shift_cnt=0, overflow=0, commit_rej=0.
REQ-027 SHALL make reset during a partial load discard the partial data; the next load SHALL restart from EMPTY.
REQ-028 SHALL make ccff_tail equal RESET_VAL[WIDTH-1] during reset.

Structure
REQ-029 SHALL place the state encoding (EMPTY/FILLING/FULL) and the CW width function in the shared package ccff_mem_pkg.
REQ-030 SHALL use one natural sub-module, ccff_shadow_chain (a WIDTH-bit enabled shift register with async reset); the counter, flags and active register SHALL live in the top module.
REQ-031 SHALL contain no latches and no combinational path from ccff_head to ccff_tail.

Verification
REQ-032 SHALL cover this case: WIDTH=3, reset, shift 1,0,1 with ccff_en -> loaded=1, shift_cnt=3, mem_out still 000; commit -> mem_out=101 next edge (bit order per REQ-016), mem_outb=010, shift_cnt=0.
REQ-033 SHALL cover this case: WIDTH=3, two shifts then commit -> commit_rej one-cycle pulse, mem_out unchanged, shift_cnt=2.
REQ-034 SHALL cover this case: WIDTH=3, four shifts -> overflow=1, ccff_tail shows the first bit shifted; commit -> overflow=0.
REQ-035 SHALL cover this case: ccff_commit and ccff_en high together while FULL -> shift occurs, commit_rej=1, active unchanged.
REQ-036 SHALL cover this case: assert prog_reset asynchronously mid-load with RESET_VAL=3'b110 -> mem_out=110 immediately, shift_cnt=0, overflow=0.
REQ-037 SHALL cover this case: WIDTH=1 and WIDTH=64 chained two-deep (tail->head) -> data emerges after 2*WIDTH shifts; both blocks commit correctly.
